lcd_bus_receiver: RTL and testbench



---
 rtl/lcd_bus_receiver_if.sv | 22 ++
 rtl/lcd_bus_receiver.sv | 194 +++++++++++++++++++
 tb/tb_lcd_bus_receiver.sv | 348 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/lcd_bus_receiver_if.sv
// HD44780-style 8-bit LCD write bus as seen between the LCD driver (master)
// and a display-side receiver (slave).
interface lcd_bus_receiver_if;
  logic       LCD_EN;
  logic       LCD_RS;
  logic       LCD_RW;
  logic [7:0] LCD_DATA;

  modport master (
    output LCD_EN,
    output LCD_RS,
    output LCD_RW,
    output LCD_DATA
  );

  modport slave (
    input LCD_EN,
    input LCD_RS,
    input LCD_RW,
    input LCD_DATA
  );
endinterface

// File: rtl/lcd_bus_receiver.sv
// Display-side LCD bus snooper: decodes enable strobes into command/data writes,
// tracks the DDRAM address counter and mirrors a readable 2x16 character buffer.
module lcd_bus_receiver #(
  parameter int unsigned MIN_EN_HIGH = 10,
  parameter logic [6:0]  LINE2_BASE  = 7'h40
) (
  input  logic                iCLK,
  input  logic                iRST_N,
  lcd_bus_receiver_if.slave   lcd_bus,
  input  logic [4:0]          iRD_ADDR,
  output logic [7:0]          oRD_CHAR,
  output logic                oCMD_VALID,
  output logic                oDATA_VALID,
  output logic [7:0]          oBYTE,
  output logic [6:0]          oADDR,
  output logic                oCLR_BUSY,
  output logic                oERR
);

  localparam int unsigned    CntW   = $clog2(MIN_EN_HIGH + 2);
  localparam logic [CntW-1:0] CntMax = '1;
  localparam logic [CntW-1:0] MinHi  = CntW'(MIN_EN_HIGH);

  typedef enum logic [1:0] {StIdle, StEnHigh, StDecode, StClear} state_e;

  logic [1:0]      r_en_sync, r_rs_sync, r_rw_sync;
  logic [7:0]      r_data_s1, r_data_s2;
  logic            r_en_prev;
  logic [CntW-1:0] r_hi_cnt;
  logic            r_rs, r_rw;
  logic [7:0]      r_byte_cap;

  state_e          r_state;
  logic            r_cmd_valid, r_data_valid, r_err, r_clr_busy;
  logic [7:0]      r_byte;
  logic [6:0]      r_addr;
  logic [4:0]      r_clr_idx;
  logic [7:0]      r_buf [32];
  logic [7:0]      r_rd_char;

  logic            w_en, w_rise, w_fall, w_fall_act, w_short, w_accept;
  logic            w_is_cmd, w_is_data, w_in_line1, w_in_line2;
  logic [6:0]      w_l2_off, w_addr_d;
  logic            w_wr_en;
  logic [4:0]      w_wr_idx;
  logic [7:0]      w_wr_data;

  // Synchronizers plus capture of the bus fields on every synchronized-high cycle.
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      r_en_sync  <= '0;
      r_rs_sync  <= '0;
      r_rw_sync  <= '0;
      r_data_s1  <= '0;
      r_data_s2  <= '0;
      r_en_prev  <= 1'b0;
      r_hi_cnt   <= '0;
      r_rs       <= 1'b0;
      r_rw       <= 1'b0;
      r_byte_cap <= '0;
    end else begin
      r_en_sync <= {r_en_sync[0], lcd_bus.LCD_EN};
      r_rs_sync <= {r_rs_sync[0], lcd_bus.LCD_RS};
      r_rw_sync <= {r_rw_sync[0], lcd_bus.LCD_RW};
      r_data_s1 <= lcd_bus.LCD_DATA;
      r_data_s2 <= r_data_s1;
      r_en_prev <= w_en;
      if (w_en) begin
        if (r_hi_cnt != CntMax) r_hi_cnt <= r_hi_cnt + 1'b1;
        r_rs       <= r_rs_sync[1];
        r_rw       <= r_rw_sync[1];
        r_byte_cap <= r_data_s2;
      end else begin
        r_hi_cnt <= '0;
      end
    end
  end

  assign w_en       = r_en_sync[1];
  assign w_rise     = w_en & ~r_en_prev;
  assign w_fall     = ~w_en & r_en_prev;
  assign w_fall_act = w_fall & (r_state != StClear);
  assign w_short    = (r_hi_cnt < MinHi);
  assign w_accept   = w_fall_act & ~w_short & ~r_rw;
  assign w_is_cmd   = w_accept & ~r_rs;
  assign w_is_data  = w_accept & r_rs;

  assign w_l2_off   = r_addr - LINE2_BASE;
  assign w_in_line1 = (r_addr < 7'd16);
  assign w_in_line2 = (w_l2_off < 7'd16);

  always_comb begin
    w_addr_d = r_addr;
    if (w_is_cmd) begin
      if (r_byte_cap == 8'h01 || r_byte_cap == 8'h02 || r_byte_cap == 8'h03) begin
        w_addr_d = '0;
      end else if (r_byte_cap[7]) begin
        w_addr_d = r_byte_cap[6:0];
      end
    end else if (w_is_data) begin
      if (r_addr == 7'h27) begin
        w_addr_d = LINE2_BASE;
      end else if (r_addr == LINE2_BASE + 7'h27) begin
        w_addr_d = '0;
      end else begin
        w_addr_d = r_addr + 7'd1;
      end
    end
  end

  // Single buffer write port shared by the clear fill and data stores.
  always_comb begin
    w_wr_en   = 1'b0;
    w_wr_idx  = '0;
    w_wr_data = 8'h20;
    if (r_state == StClear) begin
      w_wr_en  = 1'b1;
      w_wr_idx = r_clr_idx;
    end else if (w_is_data && w_in_line1) begin
      w_wr_en   = 1'b1;
      w_wr_idx  = {1'b0, r_addr[3:0]};
      w_wr_data = r_byte_cap;
    end else if (w_is_data && w_in_line2) begin
      w_wr_en   = 1'b1;
      w_wr_idx  = {1'b1, w_l2_off[3:0]};
      w_wr_data = r_byte_cap;
    end
  end

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      r_state      <= StIdle;
      r_cmd_valid  <= 1'b0;
      r_data_valid <= 1'b0;
      r_err        <= 1'b0;
      r_byte       <= '0;
      r_addr       <= '0;
      r_clr_busy   <= 1'b0;
      r_clr_idx    <= '0;
    end else begin
      r_cmd_valid  <= w_is_cmd;
      r_data_valid <= w_is_data;
      r_err        <= w_fall & ~w_accept;
      r_addr       <= w_addr_d;
      if (w_accept) r_byte <= r_byte_cap;
      unique case (r_state)
        StIdle: begin
          if (w_fall_act) r_state <= StDecode;
          else if (w_rise) r_state <= StEnHigh;
        end
        StEnHigh: begin
          if (w_fall_act) r_state <= StDecode;
        end
        StDecode: begin
          if (r_cmd_valid && r_byte == 8'h01) begin
            r_state    <= StClear;
            r_clr_busy <= 1'b1;
            r_clr_idx  <= '0;
          end else begin
            r_state <= w_en ? StEnHigh : StIdle;
          end
        end
        StClear: begin
          r_clr_idx <= r_clr_idx + 5'd1;
          if (r_clr_idx == 5'd31) begin
            r_state    <= w_en ? StEnHigh : StIdle;
            r_clr_busy <= 1'b0;
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  // Read port is write-first: a same-cycle write to the read entry is forwarded.
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      for (int i = 0; i < 32; i++) r_buf[i] <= 8'h20;
      r_rd_char <= 8'h20;
    end else begin
      if (w_wr_en) r_buf[w_wr_idx] <= w_wr_data;
      r_rd_char <= (w_wr_en && w_wr_idx == iRD_ADDR) ? w_wr_data : r_buf[iRD_ADDR];
    end
  end

  assign oRD_CHAR    = r_rd_char;
  assign oCMD_VALID  = r_cmd_valid;
  assign oDATA_VALID = r_data_valid;
  assign oBYTE       = r_byte;
  assign oADDR       = r_addr;
  assign oCLR_BUSY   = r_clr_busy;
  assign oERR        = r_err;

endmodule

// File: tb/tb_lcd_bus_receiver.sv
// Randomized self-checking bench for lcd_bus_receiver against a behavioural
// model of the character buffer, address counter and strobe acceptance rules.
module tb_lcd_bus_receiver;
  localparam int MinHi = 10;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [4:0] rd_addr;
  logic [7:0] rd_char, byte_o;
  logic       cmd_v, data_v, clr_busy, err;
  logic [6:0] addr_o;

  lcd_bus_receiver_if bus ();

  lcd_bus_receiver #(.MIN_EN_HIGH(MinHi), .LINE2_BASE(7'h40)) dut (
    .iCLK       (clk),
    .iRST_N     (rst_n),
    .lcd_bus    (bus.slave),
    .iRD_ADDR   (rd_addr),
    .oRD_CHAR   (rd_char),
    .oCMD_VALID (cmd_v),
    .oDATA_VALID(data_v),
    .oBYTE      (byte_o),
    .oADDR      (addr_o),
    .oCLR_BUSY  (clr_busy),
    .oERR       (err)
  );

  always #10 clk = ~clk;

  int n_cmp = 0;
  int n_fail = 0;

  // Behavioural model state
  logic [7:0] m_buf [32];
  logic [6:0] m_addr;
  logic [7:0] m_byte;

  typedef struct {
    logic       rs;
    logic       rw;
    logic [7:0] d;
    int         hi;
  } strobe_t;
  strobe_t q[$];

  function automatic void model_reset();
    for (int i = 0; i < 32; i++) m_buf[i] = 8'h20;
    m_addr = 7'd0;
    m_byte = 8'd0;
  endfunction

  // Buffer entry shown at a DDRAM address, or -1 if that address is off-screen.
  function automatic int idx_of(input logic [6:0] a);
    int v;
    v = int'(a);
    if (v < 16) return v;
    if (v >= 64 && v < 80) return v - 64 + 16;
    return -1;
  endfunction

  // Returns expected pulse set {cmd, data, err} and applies the write to the model.
  function automatic logic [2:0] model_apply(input strobe_t s);
    int ix;
    if (s.hi < MinHi || s.rw) return 3'b001;
    m_byte = s.d;
    if (!s.rs) begin
      if (s.d == 8'h01) begin
        for (int i = 0; i < 32; i++) m_buf[i] = 8'h20;
        m_addr = 7'd0;
      end else if (s.d == 8'h02 || s.d == 8'h03) begin
        m_addr = 7'd0;
      end else if (s.d[7]) begin
        m_addr = s.d[6:0];
      end
      return 3'b100;
    end
    ix = idx_of(m_addr);
    if (ix >= 0) m_buf[ix] = s.d;
    if (int'(m_addr) == 39) m_addr = 7'd64;
    else if (int'(m_addr) == 64 + 39) m_addr = 7'd0;
    else m_addr = m_addr + 7'd1;
    return 3'b010;
  endfunction

  function automatic void push(input logic rs, input logic rw, input logic [7:0] d, input int hi);
    strobe_t s;
    s.rs = rs; s.rw = rw; s.d = d; s.hi = hi;
    q.push_back(s);
  endfunction

  // Drives one strobe and watches 8 cycles after the pin falls for pulses.
  task automatic do_strobe(input strobe_t s, output int cyc, output logic [2:0] kinds,
                           output int npulse, output logic [7:0] rdc);
    @(negedge clk);
    bus.LCD_RS = s.rs; bus.LCD_RW = s.rw; bus.LCD_DATA = s.d; bus.LCD_EN = 1'b1;
    repeat (s.hi) @(negedge clk);
    bus.LCD_EN = 1'b0;
    cyc = 0; kinds = 3'b000; npulse = 0; rdc = 8'h00;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      if (cmd_v || data_v || err) begin
        npulse++;
        if (cyc == 0) begin
          cyc = c; kinds = {cmd_v, data_v, err}; rdc = rd_char;
        end
      end
    end
  endtask

  task automatic rd(input logic [4:0] a, output logic [7:0] v);
    @(negedge clk);
    rd_addr = a;
    @(negedge clk);
    v = rd_char;
  endtask

  task automatic test_reset();
    logic [7:0] v;
    n_cmp++;
    if (addr_o !== 7'd0 || byte_o !== 8'd0 || cmd_v !== 1'b0 || data_v !== 1'b0 ||
        err !== 1'b0 || clr_busy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_outputs: got addr=%h byte=%h cmd=%b data=%b err=%b busy=%b, want all 0",
               addr_o, byte_o, cmd_v, data_v, err, clr_busy);
    end
    n_cmp++;
    if (rd_char !== 8'h20) begin
      n_fail++; $display("FAIL reset_rd_char: got %h want 20", rd_char);
    end
    for (int i = 0; i < 32; i++) begin
      rd(5'(i), v);
      n_cmp++;
      if (v !== 8'h20) begin
        n_fail++; $display("FAIL reset_entry[%0d]: got %h want 20", i, v);
      end
    end
  endtask

  // Runs the queued strobes; each checks pulse timing/kind, address, byte and read port.
  task automatic test_strobes(input string tag);
    int cyc, np, ix, ra;
    logic [2:0] kinds, exp;
    logic [7:0] rdc, v;
    strobe_t s;
    while (q.size() > 0) begin
      s = q.pop_front();
      ix = idx_of(m_addr);
      ra = (ix >= 0) ? ix : int'($urandom_range(0, 31));
      @(negedge clk);
      rd_addr = 5'(ra);
      do_strobe(s, cyc, kinds, np, rdc);
      exp = model_apply(s);
      n_cmp++;
      if (cyc !== 3 || kinds !== exp || np !== 1) begin
        n_fail++;
        $display("FAIL %s pulse d=%h: got cyc=%0d kinds=%b n=%0d, want cyc=3 kinds=%b n=1",
                 tag, s.d, cyc, kinds, np, exp);
      end
      n_cmp++;
      if (addr_o !== m_addr) begin
        n_fail++; $display("FAIL %s addr d=%h: got %h want %h", tag, s.d, addr_o, m_addr);
      end
      n_cmp++;
      if (byte_o !== m_byte) begin
        n_fail++; $display("FAIL %s byte d=%h: got %h want %h", tag, s.d, byte_o, m_byte);
      end
      n_cmp++;
      if (rdc !== m_buf[ra]) begin
        n_fail++;
        $display("FAIL %s rd_at_pulse[%0d]: got %h want %h", tag, ra, rdc, m_buf[ra]);
      end
    end
    for (int i = 0; i < 32; i++) begin
      rd(5'(i), v);
      n_cmp++;
      if (v !== m_buf[i]) begin
        n_fail++; $display("FAIL %s entry[%0d]: got %h want %h", tag, i, v, m_buf[i]);
      end
    end
  endtask

  task automatic test_directed();
    string hola;
    hola = "HOLA";
    push(0, 0, 8'h80, 20);
    for (int i = 0; i < 4; i++) push(1, 0, hola[i], 20);
    push(0, 0, 8'hC0, 12);
    for (int i = 0; i < 17; i++) push(1, 0, 8'(8'h41 + i), 11 + (i % 5));
    test_strobes("line1_line2");
    n_cmp++;
    if (addr_o !== 7'h51) begin
      n_fail++; $display("FAIL addr_after_17: got %h want 51", addr_o);
    end
    push(0, 0, 8'hA7, 15);
    push(1, 0, "X", 15);
    push(0, 0, 8'hE7, 15);
    push(1, 0, "Y", 15);
    push(1, 0, 8'h5A, 9);
    push(1, 0, 8'h5B, 10);
    push(1, 0, 8'h5C, 5);
    push(1, 1, 8'h5D, 20);
    push(0, 1, 8'h80, 20);
    push(0, 0, 8'h02, 12);
    push(0, 0, 8'h8F, 12);
    push(1, 0, "Z", 12);
    test_strobes("wrap_minwidth");
  endtask

  task automatic test_random();
    logic rs, rw;
    logic [7:0] d;
    int hi;
    for (int n = 0; n < 40; n++) begin
      rs = 1'($urandom_range(0, 1));
      rw = ($urandom_range(0, 9) == 0);
      hi = ($urandom_range(0, 7) == 0) ? int'($urandom_range(3, 9)) : int'($urandom_range(10, 24));
      if (rs) begin
        d = 8'($urandom_range(8'h20, 8'h7e));
      end else begin
        case ($urandom_range(0, 3))
          0: d = 8'($urandom_range(2, 3));
          1: d = 8'h80 | 8'($urandom_range(0, 15));
          2: d = 8'hC0 | 8'($urandom_range(0, 15));
          default: d = 8'($urandom_range(4, 255));
        endcase
      end
      push(rs, rw, d, hi);
    end
    test_strobes("random");
  endtask

  task automatic test_clear();
    int busy_n, busy_first, busy_last, err_at, dv_n, cv_seen;
    logic [7:0] v;
    strobe_t s;
    @(negedge clk);
    bus.LCD_RS = 1'b0; bus.LCD_RW = 1'b0; bus.LCD_DATA = 8'h01; bus.LCD_EN = 1'b1;
    repeat (12) @(negedge clk);
    bus.LCD_EN = 1'b0;
    cv_seen = 0;
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk);
      if (cmd_v) cv_seen = c;
    end
    n_cmp++;
    if (cv_seen !== 3) begin
      n_fail++; $display("FAIL clear_cmd_pulse: got cycle %0d want 3", cv_seen);
    end
    s.rs = 0; s.rw = 0; s.d = 8'h01; s.hi = 12;
    void'(model_apply(s));
    busy_n = 0; busy_first = 0; busy_last = 0; err_at = 0; dv_n = 0;
    for (int c = 1; c <= 45; c++) begin
      @(negedge clk);
      if (clr_busy) begin
        busy_n++;
        if (busy_first == 0) busy_first = c;
        busy_last = c;
      end
      if (err && err_at == 0) err_at = c;
      if (data_v || cmd_v) dv_n++;
      if (c == 5) begin
        bus.LCD_RS = 1'b1; bus.LCD_DATA = "Q"; bus.LCD_EN = 1'b1;
      end
      if (c == 17) bus.LCD_EN = 1'b0;
    end
    n_cmp++;
    if (busy_n !== 32 || busy_first !== 1 || busy_last !== 32) begin
      n_fail++;
      $display("FAIL clear_busy: got n=%0d first=%0d last=%0d want 32/1/32",
               busy_n, busy_first, busy_last);
    end
    n_cmp++;
    if (err_at !== 20 || dv_n !== 0) begin
      n_fail++;
      $display("FAIL clear_drop: got err_at=%0d valids=%0d want 20/0", err_at, dv_n);
    end
    n_cmp++;
    if (addr_o !== m_addr || byte_o !== m_byte) begin
      n_fail++;
      $display("FAIL clear_state: got addr=%h byte=%h want %h/%h", addr_o, byte_o, m_addr, m_byte);
    end
    for (int i = 0; i < 32; i++) begin
      rd(5'(i), v);
      n_cmp++;
      if (v !== m_buf[i]) begin
        n_fail++; $display("FAIL clear_entry[%0d]: got %h want %h", i, v, m_buf[i]);
      end
    end
  endtask

  task automatic test_reset_mid_strobe();
    int cyc;
    logic [2:0] kinds;
    logic [7:0] v;
    @(negedge clk);
    bus.LCD_RS = 1'b1; bus.LCD_RW = 1'b0; bus.LCD_DATA = 8'h55; bus.LCD_EN = 1'b1;
    repeat (15) @(negedge clk);
    rst_n = 1'b0;
    model_reset();
    #1;
    n_cmp++;
    if (addr_o !== 7'd0 || byte_o !== 8'd0 || rd_char !== 8'h20) begin
      n_fail++;
      $display("FAIL async_reset: got addr=%h byte=%h rd=%h want 00/00/20", addr_o, byte_o, rd_char);
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (6) @(negedge clk);
    bus.LCD_EN = 1'b0;
    cyc = 0; kinds = 3'b000;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      if ((cmd_v || data_v || err) && cyc == 0) begin
        cyc = c; kinds = {cmd_v, data_v, err};
      end
    end
    n_cmp++;
    if (cyc !== 3 || kinds !== 3'b001 || addr_o !== 7'd0) begin
      n_fail++;
      $display("FAIL reset_strobe: got cyc=%0d kinds=%b addr=%h want 3/001/00", cyc, kinds, addr_o);
    end
    for (int i = 0; i < 32; i++) begin
      rd(5'(i), v);
      n_cmp++;
      if (v !== m_buf[i]) begin
        n_fail++; $display("FAIL reset_mid_entry[%0d]: got %h want %h", i, v, m_buf[i]);
      end
    end
  endtask

  initial begin
    rst_n = 1'b0;
    rd_addr = 5'd0;
    bus.LCD_EN = 1'b0; bus.LCD_RS = 1'b0; bus.LCD_RW = 1'b0; bus.LCD_DATA = 8'h00;
    model_reset();
    repeat (3) @(negedge clk);
    test_reset();
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    test_directed();
    test_clear();
    test_random();
    test_reset_mid_strobe();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
